alu_dispatch: RTL

//  Upstream issue stage for the ALU. Buffers {instr, op1, op2, tag} requests in a FIFO.

---
 rtl/alu_dispatch.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/alu_dispatch.sv
// Issue stage for the ALU: queues requests, issues them one at a time, and
// returns each result (or a timeout error) with its tag over a valid/ready port.
module alu_dispatch #(
    parameter int XLEN    = 32,
    parameter int INSTR_W = 32,
    parameter int TAG_W   = 4,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] in_instr,
    input  logic [XLEN-1:0]    in_op1,
    input  logic [XLEN-1:0]    in_op2,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               enable,
    output logic [INSTR_W-1:0] instr,
    output logic [XLEN-1:0]    op1,
    output logic [XLEN-1:0]    op2,
    input  logic               instr_exec,
    input  logic [XLEN-1:0]    result,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [XLEN-1:0]    out_result,
    output logic [TAG_W-1:0]   out_tag,
    output logic               out_err,
    output logic               busy
);
    // state | meaning
    // IDLE  | pop the FIFO head when one is queued
    // ISSUE | enable high for this single cycle
    // WAIT  | waiting for instr_exec, timer counting toward TIMEOUT-1
    // RESP  | completion held until out_ready
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(TIMEOUT);
    localparam int EW = INSTR_W + 2 * XLEN + TAG_W;

    logic [EW-1:0]      mem_q [DEPTH];
    logic [AW-1:0]      wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]      count_q;
    logic               full, empty, push, pop;
    logic [EW-1:0]      head;

    logic [1:0]         state_q, state_d;
    logic               enable_q, enable_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [XLEN-1:0]    op1_q, op1_d, op2_q, op2_d;
    logic [TAG_W-1:0]   tag_q, tag_d;
    logic [TW-1:0]      timer_q, timer_d;
    logic               out_valid_q, out_valid_d;
    logic [XLEN-1:0]    out_result_q, out_result_d;
    logic [TAG_W-1:0]   out_tag_q, out_tag_d;
    logic               out_err_q, out_err_d;

    assign full     = (count_q == CW'(DEPTH));
    assign empty    = (count_q == '0);
    assign in_ready = !full;
    assign push     = in_valid && !full;
    assign pop      = (state_q == S_IDLE) && !empty;
    assign head     = mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {in_instr, in_op1, in_op2, in_tag};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_q + CW'(push) - CW'(pop);
        end
    end

    always_comb begin
        state_d      = state_q;
        enable_d     = enable_q;
        instr_d      = instr_q;
        op1_d        = op1_q;
        op2_d        = op2_q;
        tag_d        = tag_q;
        timer_d      = timer_q;
        out_valid_d  = out_valid_q;
        out_result_d = out_result_q;
        out_tag_d    = out_tag_q;
        out_err_d    = out_err_q;
        case (state_q)
            S_IDLE: begin
                if (!empty) begin
                    {instr_d, op1_d, op2_d, tag_d} = head;
                    enable_d = 1'b1;
                    state_d  = S_ISSUE;
                end
            end
            S_ISSUE: begin
                enable_d = 1'b0;
                timer_d  = '0;
                state_d  = S_WAIT;
            end
            S_WAIT: begin
                if (instr_exec) begin
                    out_result_d = result;
                    out_err_d    = 1'b0;
                    out_tag_d    = tag_q;
                    out_valid_d  = 1'b1;
                    state_d      = S_RESP;
                end else if (timer_q == TW'(TIMEOUT - 1)) begin
                    out_result_d = '0;
                    out_err_d    = 1'b1;
                    out_tag_d    = tag_q;
                    out_valid_d  = 1'b1;
                    state_d      = S_RESP;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            S_RESP: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            enable_q     <= 1'b0;
            instr_q      <= '0;
            op1_q        <= '0;
            op2_q        <= '0;
            tag_q        <= '0;
            timer_q      <= '0;
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
            out_tag_q    <= '0;
            out_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            enable_q     <= enable_d;
            instr_q      <= instr_d;
            op1_q        <= op1_d;
            op2_q        <= op2_d;
            tag_q        <= tag_d;
            timer_q      <= timer_d;
            out_valid_q  <= out_valid_d;
            out_result_q <= out_result_d;
            out_tag_q    <= out_tag_d;
            out_err_q    <= out_err_d;
        end
    end

    assign enable     = enable_q;
    assign instr      = instr_q;
    assign op1        = op1_q;
    assign op2        = op2_q;
    assign out_valid  = out_valid_q;
    assign out_result = out_result_q;
    assign out_tag    = out_tag_q;
    assign out_err    = out_err_q;
    assign busy       = (state_q != S_IDLE) || !empty;

endmodule
